// File: rtl/run_checker_if.sv
// Bus between a program-run driver and the run checker: expected-table load,
// core write-back/store snoop, and the checker's status outputs.
interface run_checker_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic              exp_we;
  logic [AW-1:0]     exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              exp_chk;
  logic              rf_we;
  logic [AW-1:0]     rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              MemWrite;
  logic [DATA_W-1:0] DataAdr;
  logic              busy;
  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [AW-1:0]     fail_reg;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  writes;

  modport master (
    output start, exp_we, exp_addr, exp_data, exp_chk,
    output rf_we, rf_wa, rf_wd, MemWrite, DataAdr,
    input  busy, done, pass, fail_code, fail_reg, cycles, writes
  );

  modport slave (
    input  start, exp_we, exp_addr, exp_data, exp_chk,
    input  rf_we, rf_wa, rf_wd, MemWrite, DataAdr,
    output busy, done, pass, fail_code, fail_reg, cycles, writes
  );
endinterface

// File: rtl/run_checker.sv
// Shadows a core's register write-backs during a program run, then compares the
// shadow against a loaded expected table once the core stores to the halt address.
module run_checker #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREGS      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned HALT_ADR   = 100
) (
  input  logic         clk,
  input  logic         reset,
  run_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} stateT;

  localparam logic [AW:0] nRegsExt = (AW+1)'(NREGS);

  stateT             state;
  logic [AW-1:0]     scanIdx;
  logic [DATA_W-1:0] shadow  [NREGS];
  logic [DATA_W-1:0] expData [NREGS];
  logic [NREGS-1:0]  expChk;

  logic wrInRange;
  logic expInRange;
  logic haltHit;
  logic timeoutHit;
  logic scanMismatch;

  assign wrInRange    = {1'b0, bus.rf_wa} < nRegsExt;
  assign expInRange   = {1'b0, bus.exp_addr} < nRegsExt;
  assign haltHit      = bus.MemWrite && (bus.DataAdr == DATA_W'(HALT_ADR));
  assign timeoutHit   = bus.cycles == CNT_W'(MAX_CYCLES - 1);
  assign scanMismatch = expChk[scanIdx] && (shadow[scanIdx] != expData[scanIdx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      scanIdx       <= '0;
      expChk        <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.fail_code <= 2'd0;
      bus.fail_reg  <= '0;
      bus.cycles    <= '0;
      bus.writes    <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        shadow[i]  <= '0;
        expData[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.exp_we && expInRange) begin
            expData[bus.exp_addr] <= bus.exp_data;
            expChk[bus.exp_addr]  <= bus.exp_chk;
          end
          if (bus.start) begin
            state         <= RUN;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.fail_code <= 2'd0;
            bus.fail_reg  <= '0;
            bus.cycles    <= '0;
            bus.writes    <= '0;
            for (int unsigned i = 0; i < NREGS; i++) shadow[i] <= '0;
          end
        end

        RUN: begin
          // A write-back in the halt cycle still lands before the scan begins.
          if (bus.rf_we && wrInRange) begin
            shadow[bus.rf_wa] <= bus.rf_wd;
            bus.writes        <= bus.writes + CNT_W'(1);
          end
          if (haltHit) begin
            state   <= COMPARE;
            scanIdx <= '0;
          end else if (timeoutHit) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.pass      <= 1'b0;
            bus.fail_code <= 2'd2;
          end else if (bus.cycles != '1) begin
            bus.cycles <= bus.cycles + CNT_W'(1);
          end
        end

        COMPARE: begin
          // One index per cycle; don't-care entries still take their slot.
          if (scanMismatch) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.pass      <= 1'b0;
            bus.fail_code <= 2'd1;
            bus.fail_reg  <= scanIdx;
          end else if (scanIdx == AW'(NREGS - 1)) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.pass      <= 1'b1;
            bus.fail_code <= 2'd0;
          end else begin
            scanIdx <= scanIdx + AW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
